// File: rtl/add_share_sched_if.sv
// Handshake bundle between the requester front-ends and the shared-adder scheduler.
// The master side offers operands and consumes results; the slave side is the scheduler.
interface add_share_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_carry;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_id, busy
  );
endinterface

// File: rtl/add_share_sched.sv
// Round-robin scheduler time-sharing one WIDTH-bit adder among NREQ requesters.
// state  | meaning
// IDLE   | pick a round-robin winner, accept its operands on this edge
// CALC   | register {carry,sum} of the latched operands
// RESULT | present tagged result until the consumer accepts it
module add_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst,
  add_share_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   op_id;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
      b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
    end
  end

  // Search starts one past the last served requester, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (!rst && state == IDLE && found)
      bus.req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= IDW'(NREQ - 1);
      op_a          <= '0;
      op_b          <= '0;
      op_id         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_carry <= 1'b0;
      bus.res_id    <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a     <= a_arr[winner];
            op_b     <= b_arr[winner];
            op_id    <= winner;
            state    <= CALC;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          {bus.res_carry, bus.res_sum} <= {1'b0, op_a} + {1'b0, op_b};
          bus.res_id    <= op_id;
          bus.res_valid <= 1'b1;
          state         <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            last          <= bus.res_id;
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.res_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
